// File: rtl/dt_pass_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dt_pass_sequencer
// Description : Sequences the two-pass chamfer distance transform in place
//               over the result RAM. Optional macro DT_BACKWARD_EN adds the
//               reverse backward pass; without it only the forward pass runs.
// Revision    : 1.0 - initial release
// ============================================================================
module dt_pass_sequencer #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int AW    = 14,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          res_rd,
    output logic          res_wr,
    output logic [AW-1:0] res_addr,
    output logic [DW-1:0] res_do,
    input  logic [DW-1:0] res_di
);

    localparam int c_CW = $clog2(IMG_W);
    localparam int c_RW = AW - c_CW;
    localparam logic [c_CW-1:0] c_COL_LO = c_CW'(1);
    localparam logic [c_CW-1:0] c_COL_HI = c_CW'(IMG_W - 2);
    localparam logic [c_RW-1:0] c_ROW_LO = c_RW'(1);
    localparam logic [c_RW-1:0] c_ROW_HI = c_RW'(IMG_H - 2);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDC  = 3'd1,
        S_CHK  = 3'd2,
        S_RDN  = 3'd3,
        S_LAST = 3'd4,
        S_WR   = 3'd5,
        S_FIN  = 3'd6
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_RW-1:0] r_row, w_row_nxt, w_adv_row, w_nrow;
    logic [c_CW-1:0] r_col, w_col_nxt, w_adv_col, w_ncol;
    logic [1:0]      r_k, w_k_nxt;
    logic [DW-1:0]   r_min, w_min_nxt;
    logic [DW-1:0]   r_res, w_res_nxt;
    logic            r_done, w_done_nxt;
    logic            w_adv, w_last_px, w_bwd;
    logic [DW-1:0]   w_min4, w_sat, w_res;
    logic [DW:0]     w_inc;

`ifdef DT_BACKWARD_EN
    logic            r_bwd, w_bwd_nxt;
    logic [DW-1:0]   r_centre, w_centre_nxt;
    assign w_bwd = r_bwd;
`else
    assign w_bwd = 1'b0;
`endif

    // Running minimum over the four neighbours; +1 carried in DW+1 bits so it can saturate.
    assign w_min4 = (res_di < r_min) ? res_di : r_min;
    assign w_inc  = {1'b0, w_min4} + (DW+1)'(1);
    assign w_sat  = w_inc[DW] ? {DW{1'b1}} : w_inc[DW-1:0];
`ifdef DT_BACKWARD_EN
    assign w_res  = (w_bwd && (r_centre < w_sat)) ? r_centre : w_sat;
`else
    assign w_res  = w_sat;
`endif

    assign done = r_done;

    always_comb begin
        w_nrow = r_row;
        w_ncol = r_col;
        if (!w_bwd) begin
            case (r_k)
                2'd0: begin w_nrow = r_row - c_RW'(1); w_ncol = r_col - c_CW'(1); end
                2'd1: begin w_nrow = r_row - c_RW'(1); w_ncol = r_col;            end
                2'd2: begin w_nrow = r_row - c_RW'(1); w_ncol = r_col + c_CW'(1); end
                default: begin w_nrow = r_row;         w_ncol = r_col - c_CW'(1); end
            endcase
        end
`ifdef DT_BACKWARD_EN
        else begin
            case (r_k)
                2'd0: begin w_nrow = r_row;            w_ncol = r_col + c_CW'(1); end
                2'd1: begin w_nrow = r_row + c_RW'(1); w_ncol = r_col - c_CW'(1); end
                2'd2: begin w_nrow = r_row + c_RW'(1); w_ncol = r_col;            end
                default: begin w_nrow = r_row + c_RW'(1); w_ncol = r_col + c_CW'(1); end
            endcase
        end
`endif
    end

    always_comb begin
        w_adv_row = r_row;
        w_adv_col = r_col;
        w_last_px = 1'b0;
        if (!w_bwd) begin
            w_last_px = (r_row == c_ROW_HI) && (r_col == c_COL_HI);
            if (r_col == c_COL_HI) begin
                w_adv_col = c_COL_LO;
                w_adv_row = r_row + c_RW'(1);
            end else begin
                w_adv_col = r_col + c_CW'(1);
            end
        end
`ifdef DT_BACKWARD_EN
        else begin
            w_last_px = (r_row == c_ROW_LO) && (r_col == c_COL_LO);
            if (r_col == c_COL_LO) begin
                w_adv_col = c_COL_HI;
                w_adv_row = r_row - c_RW'(1);
            end else begin
                w_adv_col = r_col - c_CW'(1);
            end
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_k_nxt     = r_k;
        w_min_nxt   = r_min;
        w_res_nxt   = r_res;
        w_done_nxt  = r_done;
        w_adv       = 1'b0;
`ifdef DT_BACKWARD_EN
        w_bwd_nxt    = r_bwd;
        w_centre_nxt = r_centre;
`endif
        busy     = 1'b0;
        res_rd   = 1'b0;
        res_wr   = 1'b0;
        res_addr = '0;
        res_do   = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RDC;
                    w_row_nxt   = c_ROW_LO;
                    w_col_nxt   = c_COL_LO;
                    w_done_nxt  = 1'b0;
`ifdef DT_BACKWARD_EN
                    w_bwd_nxt   = 1'b0;
`endif
                end
            end
            S_RDC: begin
                busy        = 1'b1;
                res_rd      = 1'b1;
                res_addr    = {r_row, r_col};
                w_state_nxt = S_CHK;
            end
            S_CHK: begin
                busy = 1'b1;
`ifdef DT_BACKWARD_EN
                w_centre_nxt = res_di;
`endif
                if (res_di == '0) begin
                    w_adv = 1'b1;
                end else begin
                    w_k_nxt     = 2'd0;
                    w_state_nxt = S_RDN;
                end
            end
            S_RDN: begin
                busy     = 1'b1;
                res_rd   = 1'b1;
                res_addr = {w_nrow, w_ncol};
                // Data for neighbour k-1 arrives while neighbour k is being addressed.
                if (r_k == 2'd1) begin
                    w_min_nxt = res_di;
                end else if (r_k != 2'd0) begin
                    w_min_nxt = w_min4;
                end
                w_k_nxt = r_k + 2'd1;
                if (r_k == 2'd3) begin
                    w_state_nxt = S_LAST;
                end
            end
            S_LAST: begin
                busy        = 1'b1;
                w_res_nxt   = w_res;
                w_state_nxt = S_WR;
            end
            S_WR: begin
                busy     = 1'b1;
                res_wr   = 1'b1;
                res_addr = {r_row, r_col};
                res_do   = r_res;
                w_adv    = 1'b1;
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_adv) begin
            if (!w_last_px) begin
                w_row_nxt   = w_adv_row;
                w_col_nxt   = w_adv_col;
                w_state_nxt = S_RDC;
            end
`ifdef DT_BACKWARD_EN
            else if (!w_bwd) begin
                w_bwd_nxt   = 1'b1;
                w_row_nxt   = c_ROW_HI;
                w_col_nxt   = c_COL_HI;
                w_state_nxt = S_RDC;
            end
`endif
            else begin
                w_state_nxt = S_FIN;
                w_done_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_k     <= '0;
            r_min   <= '0;
            r_res   <= '0;
            r_done  <= 1'b0;
`ifdef DT_BACKWARD_EN
            r_bwd    <= 1'b0;
            r_centre <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_k     <= w_k_nxt;
            r_min   <= w_min_nxt;
            r_res   <= w_res_nxt;
            r_done  <= w_done_nxt;
`ifdef DT_BACKWARD_EN
            r_bwd    <= w_bwd_nxt;
            r_centre <= w_centre_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dt_pass_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dt_pass_sequencer
// Description : Scoreboard bench for dt_pass_sequencer on a 16x16 image with
//               a behavioural RAM and a loop-based distance-transform model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dt_pass_sequencer;

    localparam int W  = 16;
    localparam int H  = 16;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int N  = W * H;
`ifdef DT_BACKWARD_EN
    localparam bit c_BWD = 1'b1;
`else
    localparam bit c_BWD = 1'b0;
`endif
    localparam int c_TIMEOUT = 20000;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, res_rd, res_wr;
    logic [AW-1:0] res_addr;
    logic [DW-1:0] res_do;
    logic [DW-1:0] res_di;

    logic [DW-1:0] mem     [N];
    logic [DW-1:0] img     [N];
    int            ref_fin [N];
    logic          ld_en   = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    int pass_cnt    = 0;
    int total_cnt   = 0;
    int busy_cycles = 0;
    int exp_busy    = 0;
    bit overlap_seen = 1'b0;

    dt_pass_sequencer #(.IMG_W(W), .IMG_H(H), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .res_rd   (res_rd),
        .res_wr   (res_wr),
        .res_addr (res_addr),
        .res_do   (res_do),
        .res_di   (res_di)
    );

    always #5 clk = ~clk;

    // Result RAM: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (res_wr) mem[res_addr] <= res_do;
        if (res_rd) res_di <= mem[res_addr];
    end

    function automatic void check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endfunction

    // Monitor: every DUT write is matched against the next expected write.
    always @(negedge clk) begin
        if (res_rd && res_wr) overlap_seen = 1'b1;
        if (busy) busy_cycles++;
        if (!reset && res_wr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", int'(res_addr), -1);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", int'(res_addr), int'(mon_e.a));
                check("wr_data", int'(res_do), int'(mon_e.d));
            end
        end
    end

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int sat(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    // Reference: in-place chamfer transform on a copy of the current RAM.
    task automatic compute_ref();
        int  m [H][W];
        int  v;
        wr_t e;
        exp_q.delete();
        exp_busy = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                m[r][c] = int'(mem[r*W+c]);
        for (int r = 1; r <= H-2; r++) begin
            for (int c = 1; c <= W-2; c++) begin
                exp_busy += 2;
                if (m[r][c] != 0) begin
                    exp_busy += 6;
                    v = sat(min2(min2(m[r-1][c-1], m[r-1][c]), min2(m[r-1][c+1], m[r][c-1])) + 1);
                    m[r][c] = v;
                    e.a = AW'(r*W+c);
                    e.d = DW'(v);
                    exp_q.push_back(e);
                end
            end
        end
        if (c_BWD) begin
            for (int r = H-2; r >= 1; r--) begin
                for (int c = W-2; c >= 1; c--) begin
                    exp_busy += 2;
                    if (m[r][c] != 0) begin
                        exp_busy += 6;
                        v = sat(min2(min2(m[r][c+1], m[r+1][c-1]), min2(m[r+1][c], m[r+1][c+1])) + 1);
                        v = min2(m[r][c], v);
                        m[r][c] = v;
                        e.a = AW'(r*W+c);
                        e.d = DW'(v);
                        exp_q.push_back(e);
                    end
                end
            end
        end
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                ref_fin[r*W+c] = m[r][c];
    endtask

    task automatic load_mem();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = AW'(i);
            ld_data = img[i];
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic fill_random(input int dens);
        int p;
        for (int i = 0; i < N; i++) begin
            p = $urandom_range(0, 99);
            if ((i / W) == 0 || (i / W) == H-1 || (i % W) == 0 || (i % W) == W-1) img[i] = '0;
            else if (p < 3) img[i] = 8'd255;
            else img[i] = (p < dens) ? 8'd1 : 8'd0;
        end
    endtask

    task automatic run(input string tag, input bit repulse);
        int cyc;
        int bad;
        compute_ref();
        overlap_seen = 1'b0;
        @(negedge clk);
        busy_cycles = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_first_rd"}, int'({res_rd, res_addr}), int'({1'b1, AW'(W+1)}));
        check({tag, "_done_clr"}, int'({busy, done}), 2);
        if (repulse) begin
            repeat (40) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < c_TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_timeout"}, int'(cyc < c_TIMEOUT), 1);
        check({tag, "_busy_cycles"}, busy_cycles, exp_busy);
        check({tag, "_pending_writes"}, exp_q.size(), 0);
        check({tag, "_rd_wr_overlap"}, int'(overlap_seen), 0);
        bad = 0;
        for (int i = 0; i < N; i++) if (int'(mem[i]) != ref_fin[i]) bad++;
        check({tag, "_ram_diffs"}, bad, 0);
        repeat (3) @(negedge clk);
        check({tag, "_done_held"}, int'({busy, done}), 1);
    endtask

    initial begin
        int cyc;
        // Reset held three cycles.
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags", int'({busy, done, res_rd, res_wr}), 0);
        check("rst_addr", int'(res_addr), 0);
        check("rst_do", int'(res_do), 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (img[i]) img[i] = '0;
        load_mem();
        run("zero", 1'b0);
        check("zero_busy_const", busy_cycles, c_BWD ? 784 : 392);

        foreach (img[i]) img[i] = '0;
        img[8*W+8] = 8'd1;
        load_mem();
        run("single", 1'b0);
        check("single_val", int'(mem[8*W+8]), 1);

        foreach (img[i]) img[i] = '0;
        for (int r = 4; r <= 6; r++)
            for (int c = 4; c <= 6; c++)
                img[r*W+c] = 8'd1;
        load_mem();
        run("block", 1'b0);
        check("block_centre", int'(mem[5*W+5]), 2);
        check("block_corner", int'(mem[4*W+4]), 1);

        foreach (img[i]) img[i] = 8'd255;
        load_mem();
        run("saturate", 1'b0);
        check("saturate_val", int'(mem[1*W+1]), 255);

        // Start coinciding with reset must be ignored.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_ignored", int'({busy, done, res_rd}), 0);

        for (int t = 0; t < 5; t++) begin
            fill_random(20 + 18 * t);
            load_mem();
            run($sformatf("rand%0d", t), t == 2);
        end

        // Abort mid-run with reset, then restart on the partially updated RAM.
        fill_random(70);
        load_mem();
        compute_ref();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_idle", int'({busy, done, res_rd, res_wr}), 0);
        check("abort_addr", int'(res_addr), 0);
        exp_q.delete();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run("restart", 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
